// File: rtl/pipe_pal_pkg.sv
// pipe_pal_pkg
//   Shared definitions for the pipe_pal_chain pipeline:
//   - clog2 / cnt_width: compile-time width helpers for the occupancy count
//   - CNT_EXTRA: occupancy range beyond DEPTH (empty state plus skid entry)
//   - cnt_op_e: decoded occupancy update ({in_xfer, out_xfer})
package pipe_pal_pkg;

  // Count values 0..DEPTH+1 need DEPTH+2 distinct codes.
  localparam int CNT_EXTRA = 2;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + CNT_EXTRA);
  endfunction

endpackage

// File: rtl/pipe_pal_stage.sv
// pipe_pal_stage
//   One valid/data register of the pipeline (also used as the skid entry).
//   Ports:
//     i_clk, resetn     clock, asynchronous active-low reset
//     clear             synchronous clear of the valid bit (wins over load)
//     load              capture d_valid/d_data this edge
//     d_valid, d_data   incoming beat
//     q_valid, q_data   held beat
module pipe_pal_stage
  import pipe_pal_pkg::*;
#(
  parameter int W_DATA = 32
)(
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              load,
  input  logic              d_valid,
  input  logic [W_DATA-1:0] d_data,
  output logic              q_valid,
  output logic [W_DATA-1:0] q_data
);

  // Valid bit: cleared by reset or flush, otherwise follows the loaded beat.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      q_valid <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
    end
  end

  // Data only moves with a real beat, so bubbles do not toggle the data bus.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      q_data <= {W_DATA{1'b0}};
    end else if (load && d_valid && !clear) begin
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_pal_chain.sv
// pipe_pal_chain
//   Bubble-collapsing valid/ready pipeline of DEPTH stages behind a one-entry
//   skid register. o_ready is a flop (skid empty after the edge), so there is
//   no combinational path from i_ready back to o_ready.
//   Ports:
//     i_clk, resetn      clock, asynchronous active-low reset
//     i_flush            synchronous discard of every held beat
//     i_valid/o_ready    upstream handshake, i_data upstream beat
//     o_valid/i_ready    downstream handshake, o_data downstream beat
//     o_count            beats held (stages + skid), 0..DEPTH+1
module pipe_pal_chain
  import pipe_pal_pkg::*;
#(
  parameter int  W_DATA = 32,
  parameter int  DEPTH  = 4,
  localparam int W_CNT  = cnt_width(DEPTH)
)(
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data,
  output logic [W_CNT-1:0]  o_count
);

  logic              stg_valid_s [DEPTH];
  logic [W_DATA-1:0] stg_data_s  [DEPTH];
  logic [DEPTH-1:0]  load_s;
  logic              skid_valid_s;
  logic [W_DATA-1:0] skid_data_s;
  logic              skid_load_s;
  logic              sv_next_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              head_valid_s;
  logic [W_DATA-1:0] head_data_s;
  logic [W_CNT-1:0]  count_next_s;
  cnt_op_e           cnt_op_s;

  assign in_xfer_s  = i_valid & o_ready;
  assign out_xfer_s = o_valid & i_ready;

  // Stage k may load when it or any stage below it is empty, or the consumer
  // takes the tail beat; this is the expanded form of !v[k] | (v[k] & load[k+1]).
  always_comb begin
    logic acc;
    load_s = {DEPTH{1'b0}};
    acc    = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc       = acc | ~stg_valid_s[k];
      load_s[k] = acc;
    end
  end

  // Stage 0 always takes the skid first so beat order is preserved.
  always_comb begin
    head_valid_s = skid_valid_s | in_xfer_s;
    if (skid_valid_s) begin
      head_data_s = skid_data_s;
    end else begin
      head_data_s = i_data;
    end
  end

  // Skid occupancy after the edge: drains into stage 0 or captures a beat
  // that stage 0 cannot take this cycle.
  always_comb begin
    if (i_flush) begin
      sv_next_s   = 1'b0;
      skid_load_s = 1'b0;
    end else if (skid_valid_s) begin
      sv_next_s   = ~load_s[0];
      skid_load_s = load_s[0];
    end else begin
      sv_next_s   = in_xfer_s & ~load_s[0];
      skid_load_s = in_xfer_s & ~load_s[0];
    end
  end

  pipe_pal_stage #(.W_DATA(W_DATA)) u_skid (
    .i_clk   (i_clk),
    .resetn  (resetn),
    .clear   (i_flush),
    .load    (skid_load_s),
    .d_valid (~skid_valid_s),
    .d_data  (i_data),
    .q_valid (skid_valid_s),
    .q_data  (skid_data_s)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              in_valid_s;
    logic [W_DATA-1:0] in_data_s;
    if (k == 0) begin : g_head
      assign in_valid_s = head_valid_s;
      assign in_data_s  = head_data_s;
    end else begin : g_body
      assign in_valid_s = stg_valid_s[k-1];
      assign in_data_s  = stg_data_s[k-1];
    end
    pipe_pal_stage #(.W_DATA(W_DATA)) u_stage (
      .i_clk   (i_clk),
      .resetn  (resetn),
      .clear   (i_flush),
      .load    (load_s[k]),
      .d_valid (in_valid_s),
      .d_data  (in_data_s),
      .q_valid (stg_valid_s[k]),
      .q_data  (stg_data_s[k])
    );
  end

  assign o_valid = stg_valid_s[DEPTH-1];
  assign o_data  = stg_data_s[DEPTH-1];

  // o_ready reflects whether the skid will be empty after this edge.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      o_ready <= 1'b0;
    end else begin
      o_ready <= ~sv_next_s;
    end
  end

  // Occupancy update; a flushed input beat is dropped and never counted.
  always_comb begin
    cnt_op_s     = cnt_op_e'({in_xfer_s, out_xfer_s});
    count_next_s = o_count;
    if (i_flush) begin
      count_next_s = {W_CNT{1'b0}};
    end else begin
      case (cnt_op_s)
        CNT_INC:  count_next_s = o_count + W_CNT'(1'b1);
        CNT_DEC:  count_next_s = o_count - W_CNT'(1'b1);
        default:  count_next_s = o_count;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      o_count <= {W_CNT{1'b0}};
    end else begin
      o_count <= count_next_s;
    end
  end

endmodule

// File: tb/tb_pipe_pal_chain.sv
// tb_pipe_pal_chain
//   Scoreboard bench: two instances (DEPTH=4/W_DATA=32 and DEPTH=1/W_DATA=8).
//   Inputs change on the falling edge; handshakes are decided from the
//   registered outputs seen just after that, and occupancy is compared with
//   the scoreboard depth after every rising edge.
module tb_pipe_pal_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        flush4, valid4, ready4;
  logic [31:0] data4;
  logic        o_ready4, o_valid4;
  logic [31:0] o_data4;
  logic [2:0]  o_count4;

  logic        flush1, valid1, ready1;
  logic [7:0]  data1;
  logic        o_ready1, o_valid1;
  logic [7:0]  o_data1;
  logic [1:0]  o_count1;

  pipe_pal_chain #(.W_DATA(32), .DEPTH(4)) dut4 (
    .i_clk(clk), .resetn(resetn), .i_flush(flush4),
    .i_valid(valid4), .o_ready(o_ready4), .i_data(data4),
    .o_valid(o_valid4), .i_ready(ready4), .o_data(o_data4),
    .o_count(o_count4)
  );

  pipe_pal_chain #(.W_DATA(8), .DEPTH(1)) dut1 (
    .i_clk(clk), .resetn(resetn), .i_flush(flush1),
    .i_valid(valid1), .o_ready(o_ready1), .i_data(data1),
    .o_valid(o_valid1), .i_ready(ready1), .o_data(o_data1),
    .o_count(o_count1)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q4[$];
  logic [7:0]  q1[$];
  int          acc4;
  logic        seen_valid4;
  logic        seen_ready4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on dut4; called at a falling edge, returns at the next one.
  task automatic step4(input logic val, input logic [31:0] dat, input logic rdy, input logic fl);
    logic [31:0] exp;
    valid4 = val; data4 = dat; ready4 = rdy; flush4 = fl;
    #1;
    seen_valid4 = o_valid4;
    seen_ready4 = o_ready4;
    if (o_valid4 && rdy) begin
      check("q4_has_entry", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        exp = q4.pop_front();
        check("o_data4", 64'(o_data4), 64'(exp));
      end
    end
    if (fl) q4.delete();
    else if (val && o_ready4) begin
      q4.push_back(dat);
      acc4++;
    end
    @(posedge clk); #1;
    check("o_count4", 64'(o_count4), 64'(q4.size()));
    @(negedge clk);
  endtask

  // One cycle on dut1 (no flush), same phasing as step4.
  task automatic step1(input logic val, input logic [7:0] dat, input logic rdy);
    logic [7:0] exp;
    valid1 = val; data1 = dat; ready1 = rdy; flush1 = 1'b0;
    #1;
    if (o_valid1 && rdy) begin
      check("q1_has_entry", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        exp = q1.pop_front();
        check("o_data1", 64'(o_data1), 64'(exp));
      end
    end
    if (val && o_ready1) q1.push_back(dat);
    @(posedge clk); #1;
    check("o_count1", 64'(o_count1), 64'(q1.size()));
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    flush4 = 1'b0; valid4 = 1'b0; ready4 = 1'b0; data4 = 32'd0;
    flush1 = 1'b0; valid1 = 1'b0; ready1 = 1'b0; data1 = 8'd0;
    acc4 = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", 64'(o_valid4), 64'd0);
    check("rst_ready", 64'(o_ready4), 64'd0);
    check("rst_count", 64'(o_count4), 64'd0);
    check("rst_data",  64'(o_data4),  64'd0);
    check("rst_count1", 64'(o_count1), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rel_ready4", 64'(o_ready4), 64'd1);
    check("rel_ready1", 64'(o_ready1), 64'd1);
    @(negedge clk);

    // Streaming: beats 1..8, first out after 4 cycles, no gaps
    for (int i = 0; i < 12; i++) begin
      step4(i < 8, 32'(i + 1), 1'b1, 1'b0);
      check("stream_valid", 64'(seen_valid4), 64'(i >= 4 && i <= 11));
    end

    // Stall: exactly DEPTH+1 beats accepted, o_ready drops after the 5th
    acc4 = 0;
    for (int i = 0; i < 8; i++) begin
      step4(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      check("stall_ready", 64'(seen_ready4), 64'(i < 5));
    end
    check("stall_accepted", 64'(acc4), 64'd5);
    check("stall_count", 64'(o_count4), 64'd5);
    step4(1'b1, 32'h200, 1'b1, 1'b0);
    check("release_ready", 64'(o_ready4), 64'd1);
    repeat (8) step4(1'b0, 32'd0, 1'b1, 1'b0);
    check("stall_drained", 64'(q4.size()), 64'd0);

    // Hole collapse: beats at cycles 0 and 3 under stall end up adjacent
    step4(1'b1, 32'hA1, 1'b0, 1'b0);
    repeat (2) step4(1'b0, 32'd0, 1'b0, 1'b0);
    step4(1'b1, 32'hB2, 1'b0, 1'b0);
    repeat (4) step4(1'b0, 32'd0, 1'b0, 1'b0);
    check("collapse_count", 64'(o_count4), 64'd2);
    for (int i = 0; i < 2; i++) begin
      step4(1'b0, 32'd0, 1'b1, 1'b0);
      check("collapse_b2b", 64'(seen_valid4), 64'd1);
    end
    check("collapse_empty", 64'(o_valid4), 64'd0);

    // Flush of a full pipe with head handshake and an input beat present
    for (int i = 0; i < 6; i++) step4(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    check("full_ready", 64'(o_ready4), 64'd0);
    step4(1'b1, 32'h3FF, 1'b1, 1'b1);
    check("flush_valid", 64'(o_valid4), 64'd0);
    check("flush_ready", 64'(o_ready4), 64'd1);
    check("flush_count", 64'(o_count4), 64'd0);
    // Flush while o_ready=1: the presented beat is dropped
    step4(1'b1, 32'h400, 1'b1, 1'b0);
    step4(1'b1, 32'h401, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step4(1'b0, 32'd0, 1'b1, 1'b0);
      check("post_flush_valid", 64'(seen_valid4), 64'd0);
    end

    // Asynchronous reset between edges in mid-stream
    for (int i = 0; i < 6; i++) step4(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0);
    valid4 = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid4), 64'd0);
    check("arst_ready", 64'(o_ready4), 64'd0);
    check("arst_count", 64'(o_count4), 64'd0);
    q4.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("arst_rel_ready0", 64'(o_ready4), 64'd0);
    step4(1'b0, 32'd0, 1'b1, 1'b0);
    check("arst_rel_ready1", 64'(o_ready4), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step4(1'b0, 32'd0, 1'b1, 1'b0);
      check("arst_no_ghost", 64'(seen_valid4), 64'd0);
    end

    // DEPTH=1 random traffic against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      step1(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    repeat (4) step1(1'b0, 8'd0, 1'b1);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_pal_chain.md
# pipe_pal_chain

Parametrised, bubble-collapsing valid/ready pipeline of DEPTH register stages, fronted by a one-entry skid register so that the upstream `o_ready` is a flop, not a combinational chain through every stage. It carries W_DATA-bit beats in order from a producer to a consumer. It replaces fixed single-register pipe stages wherever a configurable latency, back-pressure and a flush are needed. It also reports live occupancy for debug and credit logic.

## Interface
- W_DATA, 32, beat width in bits (≥1)
- DEPTH, 4, number of pipeline stages (≥1)
- W_CNT, $clog2(DEPTH+2), width of occupancy count (derived, not overridden)

- i_clk  in  1  clock, rising edge
- resetn  in  1  reset: asynchronous, active-low; clock i_clk
- i_flush  in  1  synchronous flush, discards all held beats
- i_valid  in  1  upstream beat valid
- o_ready  out  1  upstream may transfer (registered)
- i_data  in  W_DATA  upstream beat
- o_valid  out  1  downstream beat valid (= stage DEPTH-1 valid)
- i_ready  in  1  downstream accepts
- o_data  out  W_DATA  downstream beat (= stage DEPTH-1 data)
- o_count  out  W_CNT  beats held (stages + skid), 0..DEPTH+1

## Operation
- Storage: stages s[0..DEPTH-1], each valid bit v[k] plus data; skid register (sv, sd) ahead of s[0]. Total capacity DEPTH+1.
- Transfers: input on `i_valid & o_ready`; output on `o_valid & i_ready`.
- Advance rules, evaluated combinationally from current state:
  - adv[DEPTH-1] = v[DEPTH-1] & i_ready.
  - s[k] can load = !v[k] | adv[k]; adv[k-1] = v[k-1] & load[k].
  - Holes collapse: a beat moves into any empty downstream stage, regardless of downstream stall.
- s[0] source: skid entry if sv=1, else the input beat. The skid is always drained first, so order is preserved.
- Skid load: an input beat is accepted while sv=1 is impossible (o_ready=0). An accepted beat goes to the skid when s[0] cannot load that cycle.
- o_ready next = !sv_next (skid empty after the edge). It is 0 while resetn low.
- o_count next = o_count + in_xfer − out_xfer. When both occur it is unchanged; it never wraps.
- Flush (i_flush=1 at an edge):
  - All v[k] and sv are cleared; o_count = 0; o_ready = 1 after the edge.
  - An input beat presented that cycle is dropped.
  - An output handshake in the same cycle is a valid transfer to the consumer.
- Reset: all v[k], sv, stage data and skid data = 0. Outputs: o_valid=0, o_data=0, o_ready=0, o_count=0.
- Reset mid-stream: all beats are lost immediately (async). No beat emerges after resetn rises until new input is accepted.

## Timing
- Empty pipe, beat accepted at edge n: o_valid=1 with that beat after edge n+DEPTH-1. Latency is DEPTH cycles from presentation (DEPTH=1 gives 1 cycle).
- Full throughput: 1 beat/cycle sustained while i_ready=1.
- Downstream stall with full stages: exactly one further beat is accepted into the skid. o_ready drops after that edge.
- Stall release: o_ready returns to 1 on the edge after the skid drains into s[0]. That is one cycle after the first output transfer that frees s[0]'s path.
- No combinational path from i_ready to o_ready. A path from i_ready to stage enables is permitted.

## Structure
- Package pipe_pal_pkg: function clog2 for W_CNT; localparam for the count width formula.
- Sub-module pipe_pal_stage: one valid/data register with load enable and synchronous clear. Instantiated DEPTH times via generate. The skid reuses the same sub-module.
- Top-level holds advance logic, the o_ready flop and the occupancy counter.

## Test plan
- DEPTH=4, i_ready=1, stream 0x1..0x8 on consecutive cycles → o_data 0x1..0x8 in order, first after 4 cycles, no gaps, o_count steady at 4.
- DEPTH=4, i_ready=0, i_valid held → exactly 5 beats accepted, o_ready=0 from the following cycle, o_count=5. Then i_ready=1 for 1 cycle → o_ready=1 next cycle, order intact.
- Single beat, then i_ready=0 with beats at cycles 0 and 3 → beats collapse to adjacent stages. o_count=2; release yields both back-to-back.
- Full pipe, i_flush=1 with i_valid=1 and i_ready=1 → head beat transferred, incoming beat dropped, o_count=0, o_valid=0, o_ready=1 next cycle.
- resetn pulsed low mid-stream (async, between edges) → o_valid=0, o_ready=0, o_count=0 immediately. o_ready=1 after the first edge with resetn high.
- DEPTH=1, W_DATA=8, random i_valid/i_ready 1000 cycles → scoreboard in-order match, o_count equals scoreboard depth every cycle.
